// File: rtl/q_term.sv
// q_term: scrolling text terminal with VGA output.
// A byte stream (d/dv/dr handshake) is written into a COLS x ROWS character
// RAM. Newline, column wrap and hardware scroll are handled by a small FSM.
// The RAM is scanned out through a 4x8 glyph ROM in 5x9 pixel cells.
//   k  : pixel clock          r  : async reset, active high
//   d  : input character      dv : d valid
//   dr : ready (accept on rising k with dv && dr)
//   u  : hsync, active low    v  : vsync, active low
//   p  : pixel, 1=foreground  fs : start-of-frame pulse (pixel 0,0)
// u, v, p and fs all lag the scan counters by exactly 2 clocks.
module q_term #(
  parameter int H_ACT = 640,
  parameter int H_FP  = 16,
  parameter int H_SYN = 96,
  parameter int H_BP  = 48,
  parameter int V_ACT = 480,
  parameter int V_FP  = 10,
  parameter int V_SYN = 2,
  parameter int V_BP  = 33,
  parameter int COLS  = 128,
  parameter int ROWS  = 53,
  parameter int NL    = 10
) (
  input  logic       k,
  input  logic       r,
  input  logic [7:0] d,
  input  logic       dv,
  output logic       dr,
  output logic       u,
  output logic       v,
  output logic       p,
  output logic       fs
);

  localparam int HT    = H_ACT + H_FP + H_SYN + H_BP;
  localparam int VT    = V_ACT + V_FP + V_SYN + V_BP;
  localparam int XW    = $clog2(HT);
  localparam int YW    = $clog2(VT);
  localparam int CXW   = $clog2(HT / 5 + 1);
  localparam int CYW   = $clog2(VT / 9 + 1);
  localparam int CELLS = ROWS * COLS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} st_t;

  typedef struct packed {
    logic       vld;
    logic       hs;
    logic       vs;
    logic       sof;
    logic [2:0] gy;
    logic [1:0] gx;
  } pix_t;

  // 4x8 glyphs, row 0 in bits [31:28], leftmost pixel in the nibble MSB
  function automatic logic [31:0] glyph(input logic [6:0] c);
    case (c)
      7'd32:  glyph = 32'h00000000; 7'd33:  glyph = 32'h44444040; 7'd34:  glyph = 32'hAA000000; 7'd35:  glyph = 32'hAEAEA000;
      7'd36:  glyph = 32'h46842C40; 7'd37:  glyph = 32'hA2448A00; 7'd38:  glyph = 32'h4A4AA600; 7'd39:  glyph = 32'h44000000;
      7'd40:  glyph = 32'h24888420; 7'd41:  glyph = 32'h84222480; 7'd42:  glyph = 32'h0A4E4A00; 7'd43:  glyph = 32'h044E4400;
      7'd44:  glyph = 32'h00000448; 7'd45:  glyph = 32'h000E0000; 7'd46:  glyph = 32'h00000040; 7'd47:  glyph = 32'h22448800;
      7'd48:  glyph = 32'hEAAAAAE0; 7'd49:  glyph = 32'h4C4444E0; 7'd50:  glyph = 32'hE22E88E0; 7'd51:  glyph = 32'hE22E22E0;
      7'd52:  glyph = 32'hAAAE2220; 7'd53:  glyph = 32'hE88E22E0; 7'd54:  glyph = 32'hE88EAAE0; 7'd55:  glyph = 32'hE2224440;
      7'd56:  glyph = 32'hEAAEAAE0; 7'd57:  glyph = 32'hEAAE22E0; 7'd58:  glyph = 32'h00400400; 7'd59:  glyph = 32'h00400448;
      7'd60:  glyph = 32'h02484200; 7'd61:  glyph = 32'h00E0E000; 7'd62:  glyph = 32'h08424800; 7'd63:  glyph = 32'hE2264040;
      7'd64:  glyph = 32'hEAEEE8E0; 7'd65:  glyph = 32'h4AAEAAA0; 7'd66:  glyph = 32'hCAACAAC0; 7'd67:  glyph = 32'h68888860;
      7'd68:  glyph = 32'hCAAAAAC0; 7'd69:  glyph = 32'hE88E88E0; 7'd70:  glyph = 32'hE88E8880; 7'd71:  glyph = 32'h688AAA60;
      7'd72:  glyph = 32'hAAAEAAA0; 7'd73:  glyph = 32'hE44444E0; 7'd74:  glyph = 32'h22222A40; 7'd75:  glyph = 32'hAAC8CAA0;
      7'd76:  glyph = 32'h888888E0; 7'd77:  glyph = 32'hAEEAAAA0; 7'd78:  glyph = 32'hCAAAAAA0; 7'd79:  glyph = 32'h4AAAAA40;
      7'd80:  glyph = 32'hCAAC8880; 7'd81:  glyph = 32'h4AAAAE60; 7'd82:  glyph = 32'hCAACAAA0; 7'd83:  glyph = 32'h688422C0;
      7'd84:  glyph = 32'hE4444440; 7'd85:  glyph = 32'hAAAAAAE0; 7'd86:  glyph = 32'hAAAAAA40; 7'd87:  glyph = 32'hAAAAEEA0;
      7'd88:  glyph = 32'hAAA4AAA0; 7'd89:  glyph = 32'hAAA44440; 7'd90:  glyph = 32'hE22488E0; 7'd91:  glyph = 32'hC88888C0;
      7'd92:  glyph = 32'h88442200; 7'd93:  glyph = 32'h62222260; 7'd94:  glyph = 32'h4A000000; 7'd95:  glyph = 32'h000000E0;
      7'd96:  glyph = 32'h84000000; 7'd97:  glyph = 32'h00C26A60; 7'd98:  glyph = 32'h88CAAAC0; 7'd99:  glyph = 32'h00688860;
      7'd100: glyph = 32'h226AAA60; 7'd101: glyph = 32'h004AE860; 7'd102: glyph = 32'h24E44440; 7'd103: glyph = 32'h006AA62C;
      7'd104: glyph = 32'h88CAAAA0; 7'd105: glyph = 32'h40C444E0; 7'd106: glyph = 32'h202222A4; 7'd107: glyph = 32'h88ACCAA0;
      7'd108: glyph = 32'hC44444E0; 7'd109: glyph = 32'h00AEEAA0; 7'd110: glyph = 32'h00CAAAA0; 7'd111: glyph = 32'h004AAA40;
      7'd112: glyph = 32'h00CAAC88; 7'd113: glyph = 32'h006AA622; 7'd114: glyph = 32'h00AC8880; 7'd115: glyph = 32'h006842C0;
      7'd116: glyph = 32'h44E44420; 7'd117: glyph = 32'h00AAAA60; 7'd118: glyph = 32'h00AAAA40; 7'd119: glyph = 32'h00AAEEA0;
      7'd120: glyph = 32'h00AA4AA0; 7'd121: glyph = 32'h00AAA62C; 7'd122: glyph = 32'h00E248E0; 7'd123: glyph = 32'h24484420;
      7'd124: glyph = 32'h44444440; 7'd125: glyph = 32'h84424480; 7'd126: glyph = 32'h005A0000;
      default: glyph = 32'h00000000;
    endcase
  endfunction

  // ---------------- scan counters ----------------
  // cell/glyph coordinates run alongside x/y so no dividers are needed
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [CXW-1:0] cx;
  logic [CYW-1:0] cy;
  logic [2:0]     gx;
  logic [3:0]     gy;

  always_ff @(posedge k or posedge r) begin
    if (r) begin
      x <= '0; y <= '0; cx <= '0; cy <= '0; gx <= '0; gy <= '0;
    end else if (x == XW'(HT - 1)) begin
      x <= '0; gx <= '0; cx <= '0;
      if (y == YW'(VT - 1)) begin
        y <= '0; gy <= '0; cy <= '0;
      end else begin
        y <= y + 1'b1;
        if (gy == 4'd8) begin gy <= '0; cy <= cy + 1'b1; end
        else gy <= gy + 1'b1;
      end
    end else begin
      x <= x + 1'b1;
      if (gx == 3'd4) begin gx <= '0; cx <= cx + 1'b1; end
      else gx <= gx + 1'b1;
    end
  end

  // ---------------- cursor / write FSM ----------------
  st_t            st;
  logic [AW-1:0]  cnt;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [RW-1:0]  top;

  logic           nl_c, prt_c, adv;
  logic [RW:0]    csum, wrow;
  logic [RW-1:0]  bot;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     wdata;

  always_comb begin
    nl_c  = (d == 8'(NL));
    prt_c = (d >= 8'd32) && (d <= 8'd126) && !nl_c;
    adv   = nl_c || (prt_c && (col == CW'(COLS - 1)));
    csum  = {1'b0, top} + {1'b0, row};
    wrow  = (csum >= (RW+1)'(ROWS)) ? csum - (RW+1)'(ROWS) : csum;
    // the row that scrolled in at the bottom is the old top
    bot   = (top == '0) ? RW'(ROWS - 1) : top - 1'b1;
    we    = 1'b0;
    waddr = cnt;
    wdata = 8'd32;
    case (st)
      CLR_ALL: we = 1'b1;
      CLR_ROW: begin
        we    = 1'b1;
        waddr = AW'(bot) * AW'(COLS) + cnt;
      end
      IDLE: if (dv && dr && prt_c) begin
        we    = 1'b1;
        waddr = AW'(wrow) * AW'(COLS) + AW'(col);
        wdata = d;
      end
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge k or posedge r) begin
    if (r) begin
      st <= CLR_ALL; cnt <= '0; col <= '0; row <= '0; top <= '0; dr <= 1'b0;
    end else begin
      case (st)
        CLR_ALL: if (cnt == AW'(CELLS - 1)) begin
          st <= IDLE; cnt <= '0; dr <= 1'b1;
        end else cnt <= cnt + 1'b1;
        CLR_ROW: if (cnt == AW'(COLS - 1)) begin
          st <= IDLE; cnt <= '0; dr <= 1'b1;
        end else cnt <= cnt + 1'b1;
        IDLE: if (dv && dr) begin
          if (adv) begin
            col <= '0;
            if (row != RW'(ROWS - 1)) row <= row + 1'b1;
            else begin
              top <= (top == RW'(ROWS - 1)) ? '0 : top + 1'b1;
              st  <= CLR_ROW; cnt <= '0; dr <= 1'b0;
            end
          end else if (prt_c) col <= col + 1'b1;
        end
        default: begin st <= CLR_ALL; cnt <= '0; dr <= 1'b0; end
      endcase
    end
  end

  // ---------------- character RAM ----------------
  // read-before-write: a same-cell collision returns the old byte
  logic [7:0]     mem [CELLS];
  logic [7:0]     rd_q;
  logic [AW-1:0]  raddr;
  logic [CYW:0]   psum, prow;
  logic           act0, cell0;

  always_comb begin
    act0  = (x < XW'(H_ACT)) && (y < YW'(V_ACT));
    cell0 = (gx != 3'd4) && (gy != 4'd8) && (cx < CXW'(COLS)) && (cy < CYW'(ROWS));
    psum  = {1'b0, cy} + (CYW+1)'(top);
    prow  = (psum >= (CYW+1)'(ROWS)) ? psum - (CYW+1)'(ROWS) : psum;
    raddr = cell0 ? AW'(prow) * AW'(COLS) + AW'(cx) : '0;
  end

  always_ff @(posedge k) begin
    if (we && !r) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  // ---------------- output pipeline ----------------
  pix_t        s1;
  logic [31:0] gw;
  logic [4:0]  bi;
  logic        pix;

  always_ff @(posedge k or posedge r) begin
    if (r) s1 <= '0;
    else begin
      s1.vld <= act0 && cell0;
      s1.hs  <= (x >= XW'(H_ACT + H_FP)) && (x < XW'(H_ACT + H_FP + H_SYN));
      s1.vs  <= (y >= YW'(V_ACT + V_FP)) && (y < YW'(V_ACT + V_FP + V_SYN));
      s1.sof <= (x == '0) && (y == '0);
      s1.gy  <= gy[2:0];
      s1.gx  <= gx[1:0];
    end
  end

  always_comb begin
    gw  = glyph(rd_q[6:0]);
    bi  = {s1.gy, s1.gx};
    pix = s1.vld && (rd_q >= 8'd32) && (rd_q <= 8'd126) && gw[~bi];
  end

  always_ff @(posedge k or posedge r) begin
    if (r) begin
      u <= 1'b1; v <= 1'b1; p <= 1'b0; fs <= 1'b0;
    end else begin
      u <= ~s1.hs; v <= ~s1.vs; p <= pix; fs <= s1.sof;
    end
  end

endmodule

// File: tb/tb_q_term.sv
module tb_q_term;
  localparam int H_ACT = 40, H_FP = 4, H_SYN = 6, H_BP = 6;
  localparam int V_ACT = 30, V_FP = 2, V_SYN = 2, V_BP = 2;
  localparam int COLS = 6, ROWS = 3, NL = 10;
  localparam int HT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYN + V_BP;

  logic       k = 1'b0, r = 1'b1, dv = 1'b0;
  logic [7:0] d = 8'd0;
  logic       dr, u, v, p, fs;

  int checks = 0, errors = 0;
  logic [7:0] scr [ROWS][COLS];
  int crow, ccol;
  logic [3:0] expq [$];

  q_term #(.H_ACT(H_ACT), .H_FP(H_FP), .H_SYN(H_SYN), .H_BP(H_BP),
           .V_ACT(V_ACT), .V_FP(V_FP), .V_SYN(V_SYN), .V_BP(V_BP),
           .COLS(COLS), .ROWS(ROWS), .NL(NL))
    dut (.k(k), .r(r), .d(d), .dv(dv), .dr(dr), .u(u), .v(v), .p(p), .fs(fs));

  always #5 k = ~k;

  initial begin
    #900000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gref(input logic [7:0] c);
    case (c)
      8'd65:   gref = 32'h4AAEAAA0;  // A
      8'd66:   gref = 32'hCAACAAC0;  // B
      8'd67:   gref = 32'h68888860;  // C
      8'd88:   gref = 32'hAAA4AAA0;  // X
      8'd90:   gref = 32'hE22488E0;  // Z
      default: gref = 32'h0;         // space and unused codes
    endcase
  endfunction

  // expected {u, v, p, fs} for scan position (x, y)
  function automatic logic [3:0] exp_pix(input int x, input int y);
    logic hs, vs, pb;
    logic [3:0] nib;
    logic [7:0] ch;
    int cx, cy, gx, gy;
    hs = (x >= H_ACT + H_FP) && (x < H_ACT + H_FP + H_SYN);
    vs = (y >= V_ACT + V_FP) && (y < V_ACT + V_FP + V_SYN);
    cx = x / 5; gx = x % 5; cy = y / 9; gy = y % 9;
    pb = 1'b0;
    if (x < H_ACT && y < V_ACT && gx < 4 && gy < 8 && cx < COLS && cy < ROWS) begin
      ch  = scr[cy][cx];
      nib = 4'((gref(ch) >> (28 - 4 * gy)) & 32'hF);
      pb  = nib[3 - gx];
    end
    return {~hs, ~vs, pb, (x == 0 && y == 0)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) scr[i][j] = 8'd32;
    crow = 0; ccol = 0;
  endtask

  task automatic model_adv(output bit sc);
    sc = 1'b0; ccol = 0;
    if (crow < ROWS - 1) crow++;
    else begin
      for (int i = 0; i < ROWS - 1; i++) scr[i] = scr[i + 1];
      for (int j = 0; j < COLS; j++) scr[ROWS - 1][j] = 8'd32;
      sc = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] c, output bit sc);
    int n = 0;
    sc = 1'b0;
    @(negedge k); d = c; dv = 1'b1;
    while (dr !== 1'b1 && n < 1000) begin @(negedge k); n++; end
    check("dr_wait", 32'(dr), 32'd1);
    @(posedge k); #1 dv = 1'b0;
    if (c == 8'(NL)) model_adv(sc);
    else if (c >= 8'd32 && c <= 8'd126) begin
      scr[crow][ccol] = c; ccol++;
      if (ccol == COLS) model_adv(sc);
    end
  endtask

  task automatic count_dr(input string tag, input int exp);
    int n = 0;
    while (dr !== 1'b1 && n < 100000) begin @(posedge k); #1; n++; end
    check(tag, 32'(n), 32'(exp));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_u"}, 32'(u), 32'd1);
    check({tag, "_v"}, 32'(v), 32'd1);
    check({tag, "_p"}, 32'(p), 32'd0);
    check({tag, "_fs"}, 32'(fs), 32'd0);
    check({tag, "_dr"}, 32'(dr), 32'd0);
  endtask

  // expected frame queued from the model, popped against DUT samples from fs on
  task automatic check_frame(input string tag);
    int n = 0;
    logic [3:0] e;
    for (int yy = 0; yy < VT; yy++) for (int xx = 0; xx < HT; xx++) expq.push_back(exp_pix(xx, yy));
    @(negedge k);
    while (fs !== 1'b1 && n < 2 * HT * VT) begin @(negedge k); n++; end
    check({tag, "_fs_seen"}, 32'(fs), 32'd1);
    if (fs !== 1'b1) begin expq.delete(); return; end
    for (int i = 0; i < HT * VT; i++) begin
      if (i != 0) @(negedge k);
      e = expq.pop_front();
      check($sformatf("%s_uvpf_x%0d_y%0d", tag, i % HT, i / HT), 32'({u, v, p, fs}), 32'(e));
    end
    @(negedge k);
    check({tag, "_fs_period"}, 32'(fs), 32'd1);
  endtask

  initial begin
    bit sc;
    model_clear();
    repeat (3) @(negedge k);
    check_reset("rst");
    r = 1'b0;
    count_dr("clr_all", ROWS * COLS);
    check_frame("blank");

    send(8'd65, sc);
    check_frame("glyph_a");

    repeat (COLS) send(8'd66, sc);
    send(8'd67, sc);
    check_frame("wrap");

    // non-printables are accepted back to back and dropped
    @(negedge k); d = 8'd7; dv = 1'b1;
    for (int i = 0; i < 8; i++) begin check("bel_dr", 32'(dr), 32'd1); @(negedge k); end
    dv = 1'b0;
    send(8'd127, sc);
    send(8'd0, sc);
    send(8'd88, sc);
    check_frame("drop");

    for (int i = 0; i < 2; i++) begin
      send(8'(NL), sc);
      if (sc) count_dr("clr_row", COLS);
    end
    check("scrolled", 32'(sc), 32'd1);
    send(8'd90, sc);
    check_frame("scroll");

    // reset while a row clear is running
    send(8'(NL), sc);
    check("scroll2", 32'(sc), 32'd1);
    repeat (2) @(posedge k);
    #3 r = 1'b1;
    #1 check_reset("async_rst");
    repeat (2) @(negedge k);
    r = 1'b0;
    model_clear();
    count_dr("clr_all2", ROWS * COLS);
    check_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/q_term.md
Name: q_term

Overview:
- Parametrised successor to the fixed-string VGA quine renderer: a scrolling text terminal.
- Accepts a byte stream over a valid/ready handshake and stores it in an internal character RAM of COLS x ROWS cells.
- Handles newline, column wrap and hardware scroll, and renders the RAM through the same 4x8 glyph ROM in 5x9 cells with VGA timing taken from parameters.
- Sits between the design top and the sync/pixel pins.

Parameters:
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYN, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- V_SYN, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLS, 128, text columns (COLS*5 <= H_ACT)
- ROWS, 53, text rows (ROWS*9 <= V_ACT)
- NL, 10, newline character code

Ports:
- k in 1: pixel clock
- r in 1: reset, asynchronous, active-high
- d in 8: input character
- dv in 1: d valid
- dr out 1: ready; a character is accepted on a rising k edge with dv && dr
- u out 1: hsync, active low
- v out 1: vsync, active low
- p out 1: pixel, 1 = foreground
- fs out 1: one-cycle start-of-frame pulse

Behaviour:
- Reset (async, r=1):
  - Counters x=y=0; cursor col=row=0; scroll offset top=0.
  - Outputs: u=1, v=1, p=0, fs=0, dr=0.
  - FSM enters CLR_ALL.
- Counters:
  - x wraps at HT-1, where HT = H_ACT+H_FP+H_SYN+H_BP.
  - y increments on the x wrap and wraps at VT-1, where VT = V_ACT+V_FP+V_SYN+V_BP.
  - Sync is low for x in [H_ACT+H_FP, H_ACT+H_FP+H_SYN-1] (hsync) and y in [V_ACT+V_FP, V_ACT+V_FP+V_SYN-1] (vsync).
- Output pipeline:
  - u, v, p and fs are registered with an identical latency of 2 clocks from the counter value they describe, so they remain mutually aligned.
  - fs=1 for the pixel (0,0).
- Rendering:
  - Cell column cx = x/5, glyph column gx = x%5; cell row cy = y/9, glyph row gy = y%9.
  - Physical RAM row = (top+cy) mod ROWS.
  - p=0 when any of these hold: outside active area; gx==4; gy==8; cx>=COLS; cy>=ROWS; character <32 or >126.
  - Otherwise p = glyph bit (char-32, gx, gy[2:0]), using the team's existing 4x8 glyph table for codes 32..126.
- Character RAM:
  - Dual-port: 1 write port (FSM), 1 registered read port (renderer).
  - A write and a read to the same cell in the same cycle returns the old data.
- FSM states:
  - CLR_ALL:
    - Writes space (32) to all ROWS*COLS cells, one cell per clock.
    - dr=0 throughout.
    - Goes to IDLE after the last cell.
    - Takes ROWS*COLS cycles.
  - IDLE:
    - dr=1.
    - On accept of a printable character (32..126): write it at (row, col) and increment col. If col becomes COLS, perform a line advance.
    - On accept of NL: perform a line advance. NL is never stored.
    - On accept of any other code: drop it; no state change.
  - Line advance:
    - Set col=0.
    - If row<ROWS-1: increment row and stay in IDLE.
    - Else: row stays ROWS-1, top=(top+1) mod ROWS, and go to CLR_ROW.
  - CLR_ROW:
    - dr=0.
    - Writes space to COLS cells of physical row (top+ROWS-1) mod ROWS.
    - Returns to IDLE after COLS cycles.
- Visibility:
  - A stored character is displayed as soon as the scan reaches its cell after the write edge.
  - Tearing within a frame is permitted.
- Simultaneous events:
  - A printable character landing in the last column writes first, then advances the line.
  - NL at col==0 still advances the line, so blank lines are supported.
- Handshake:
  - dv is ignored while dr=0.
  - d must be held stable by the source only in the accepting cycle.
- Reset mid-operation:
  - Any write in progress is abandoned.
  - RAM content is undefined until CLR_ALL completes.
  - Rendering resumes immediately, showing RAM content as-is.

Test Plan:
- Reset, then count cycles until dr=1 -> exactly ROWS*COLS = 6784 cycles. Sample the first frame afterwards -> p=0 everywhere.
- Free-run one frame -> 800 clocks per line and 525 lines. u low for 96 clocks starting at x=656. v low on lines 490..491. fs pulses once per 420000 clocks.
- Send "A" (65) -> the cell (0,0) pixel pattern matches glyph 65, columns 0..3 and rows 0..7. x=4 and y=8 stay 0. Cursor col=1.
- Send 128 x "B" then "C" -> row 0 is full of B. "C" appears at (row1, col0) through the column wrap.
- Send 53 NLs then "Z" -> dr drops for 128 cycles after the 53rd NL. top=1. "Z" is displayed on the bottom text row, and former row 1 is shown on screen row 0.
- Hold dv=1 with d=7 (BEL) repeatedly -> all bytes are accepted, the cursor is unchanged and no RAM writes occur. Assert r mid-CLR_ROW -> outputs take reset values asynchronously and CLR_ALL restarts.
